// File: rtl/ls_fill_responder.sv
// Local-store line-fill responder: 32 KB word-writable store that returns a 128-byte line as eight 128-bit beats LATENCY edges after accept.
// Optional LS_FILL_CRITICAL_FIRST_EN starts the burst at the beat holding the miss word. Bit 0 of every big-endian field maps to the MSB here.
module ls_fill_responder #(
    parameter int LATENCY  = 6,
    parameter int LS_BYTES = 32768
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en_i,
    input  logic [14:0]    wr_addr_i,
    input  logic [31:0]    wr_data_i,
    input  logic           fill_req_i,
    input  logic [14:0]    fill_addr_i,
    output logic           fill_ack_o,
    output logic           fill_valid_o,
    output logic [127:0]   fill_data_o,
    output logic [2:0]     fill_beat_o,
    output logic           fill_last_o,
    output logic           busy_o
);

    localparam int         LINES    = LS_BYTES / 128;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [2:0]     beat_idx_q, beat_idx_d;
    logic [3:0]     beat_cnt_q, beat_cnt_d;
    logic [1023:0]  line_q, line_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic [2:0]     beat_q, beat_d;
    logic [127:0]   data_q, data_d;

    logic [1023:0]  mem_q [LINES];
    logic [1023:0]  line_rd;
    logic [2:0]     beat_start;
    logic           wr_fire;
    logic           unused_bits;

    assign wr_fire     = wr_en_i & ~reset;
    assign unused_bits = &{1'b0, wr_addr_i[1:0], fill_addr_i[6:0]};

`ifdef LS_FILL_CRITICAL_FIRST_EN
    assign beat_start = fill_addr_i[6:4];
`else
    assign beat_start = 3'd0;
`endif

    // NOTE: the store holds program contents across reset, so it has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_addr_i[14:7]][{~wr_addr_i[6:2], 5'd0} +: 32] <= wr_data_i;
        end
    end

    // Same-cycle write is merged into the snapshot so write-before-read holds on the accept edge.
    always_comb begin
        line_rd = mem_q[fill_addr_i[14:7]];
        if (wr_fire && (wr_addr_i[14:7] == fill_addr_i[14:7])) begin
            line_rd[{~wr_addr_i[6:2], 5'd0} +: 32] = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    // NOTE: every sequential register is updated with <= so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            beat_idx_q <= 3'd0;
            beat_cnt_q <= 4'd0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            beat_q     <= 3'd0;
            data_q     <= 128'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_idx_q <= beat_idx_d;
            beat_cnt_q <= beat_cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            data_q     <= data_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_idx_d = beat_idx_q;
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        beat_d     = 3'd0;
        data_d     = 128'd0;
        case (state_q)
            S_IDLE: begin
                if (fill_req_i) begin
                    line_d     = line_rd;
                    cnt_d      = CNT_INIT;
                    beat_idx_d = beat_start;
                    beat_cnt_d = 4'd0;
                    state_d    = (LATENCY == 1) ? S_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                // Eight edges load beats; the ninth retires the last beat and frees the port.
                if (beat_cnt_q < 4'd8) begin
                    valid_d    = 1'b1;
                    beat_d     = beat_idx_q;
                    last_d     = (beat_cnt_q == 4'd7);
                    data_d     = line_q[{~beat_idx_q, 7'd0} +: 128];
                    beat_idx_d = beat_idx_q + 3'd1;
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fill_ack_o   = (state_q == S_IDLE) & fill_req_i & ~reset;
        busy_o       = (state_q != S_IDLE);
        fill_valid_o = valid_q;
        fill_last_o  = last_q;
        fill_beat_o  = beat_q;
        fill_data_o  = data_q;
    end

endmodule

// File: tb/tb_ls_fill_responder.sv
// Directed bench for ls_fill_responder: reset, basic fill, held request, snapshot isolation, reset abort, burst ordering.
module tb_ls_fill_responder;

    localparam int LAT = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [14:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          fill_req;
    logic [14:0]   fill_addr;
    logic          fill_ack;
    logic          fill_valid;
    logic [127:0]  fill_data;
    logic [2:0]    fill_beat;
    logic          fill_last;
    logic          busy;

    int            n_pass  = 0;
    int            n_total = 0;
    logic [31:0]   mdl [8192];
    logic [127:0]  got [8];

    ls_fill_responder #(.LATENCY(LAT), .LS_BYTES(32768)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .fill_req_i   (fill_req),
        .fill_addr_i  (fill_addr),
        .fill_ack_o   (fill_ack),
        .fill_valid_o (fill_valid),
        .fill_data_o  (fill_data),
        .fill_beat_o  (fill_beat),
        .fill_last_o  (fill_last),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [14:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
        mdl[a[14:2]] = d;
    endtask

    // wr_mode: 0 none, 1 write in the accept cycle, 2 write in the first wait cycle.
    task automatic run_fill(input logic [14:0] addr, input bit keep, input int wr_mode,
                            input logic [14:0] wa, input logic [31:0] wd, input int abort_k);
        logic [31:0]  snap [32];
        logic [127:0] exp_d;
        logic [2:0]   b0;
        logic [2:0]   idx;
        int           n;
        int           stray;
        fill_req  = 1'b1;
        fill_addr = addr;
        if (wr_mode == 1) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
            mdl[wa[14:2]] = wd;
        end
        for (int i = 0; i < 32; i++) snap[i] = mdl[{addr[14:7], 5'(i)}];
        #1;
        check("ack_on_request", fill_ack, 1);
        step();
        wr_en = 1'b0;
        if (!keep) fill_req = 1'b0;
        check("busy_after_accept", busy, 1);
        if (keep) check("no_ack_in_wait", fill_ack, 0);
        if (wr_mode == 2) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
            mdl[wa[14:2]] = wd;
        end
        n = 0;
        do begin
            step();
            wr_en = 1'b0;
            n++;
        end while (!fill_valid && n < 40);
        check("latency_edges", n, LAT);
`ifdef LS_FILL_CRITICAL_FIRST_EN
        b0 = addr[6:4];
`else
        b0 = 3'd0;
`endif
        for (int k = 0; k < 8; k++) begin
            idx   = b0 + 3'(k);
            exp_d = {snap[4*idx], snap[4*idx+1], snap[4*idx+2], snap[4*idx+3]};
            got[idx] = fill_data;
            check("beat_valid", fill_valid, 1);
            check("beat_index", fill_beat, idx);
            check("beat_last", fill_last, (k == 7));
            check("beat_data", fill_data, exp_d);
            check("beat_busy", busy, 1);
            if (keep) check("no_ack_in_burst", fill_ack, 0);
            if (k == abort_k) begin
                reset = 1'b1;
                wr_en = 1'b1; wr_addr = 15'h0010; wr_data = 32'h1234_5678;
                step();
                reset = 1'b0;
                wr_en = 1'b0;
                check("abort_valid", fill_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_last", fill_last, 0);
                check("abort_beat", fill_beat, 0);
                check("abort_data", fill_data, 0);
                stray = 0;
                for (int c = 0; c < 10; c++) begin
                    step();
                    if (fill_valid || busy) stray++;
                end
                check("abort_no_more_beats", stray, 0);
                return;
            end
            if (k < 7) step();
        end
        step();
        check("post_valid", fill_valid, 0);
        check("post_busy", busy, 0);
        check("post_last", fill_last, 0);
        check("post_ack", fill_ack, keep);
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = 15'd0;
        wr_data   = 32'd0;
        fill_req  = 1'b1;
        fill_addr = 15'd0;
        #1;
        check("reset_ack", fill_ack, 0);
        step();
        step();
        check("reset_ack_held", fill_ack, 0);
        check("reset_valid", fill_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_last", fill_last, 0);
        check("reset_beat", fill_beat, 0);
        check("reset_data", fill_data, 0);
        reset    = 1'b0;
        fill_req = 1'b0;
        step();
        check("idle_after_release", busy, 0);
        fill_req = 1'b1;
        #1;
        check("idle_ack", fill_ack, 1);
        fill_req = 1'b0;

        for (int i = 0; i < 32; i++) write_word(15'(4 * i), 32'(i));
        for (int i = 0; i < 32; i++) write_word(15'(128 + 4 * i), 32'(256 + i));

        run_fill(15'h0000, 1'b0, 0, 15'd0, 32'd0, -1);
        check("basic_beat0", got[0], 128'h00000000_00000001_00000002_00000003);

        run_fill(15'h0085, 1'b1, 0, 15'd0, 32'd0, -1);
        run_fill(15'h0085, 1'b0, 0, 15'd0, 32'd0, -1);
        check("held_second_beat0", got[0], 128'h00000100_00000101_00000102_00000103);

        run_fill(15'h0000, 1'b0, 2, 15'h0010, 32'hDEAD_BEEF, -1);
        check("wait_write_isolated", got[1][127:96], 32'h0000_0004);
        run_fill(15'h0000, 1'b0, 0, 15'd0, 32'd0, -1);
        check("wait_write_visible", got[1][127:96], 32'hDEAD_BEEF);

        run_fill(15'h0000, 1'b0, 1, 15'h0014, 32'hCAFE_F00D, -1);
        check("accept_write_visible", got[1][95:64], 32'hCAFE_F00D);

        run_fill(15'h0000, 1'b0, 0, 15'd0, 32'd0, 3);
        run_fill(15'h0000, 1'b0, 0, 15'd0, 32'd0, -1);
        check("reset_write_ignored", got[1][127:96], 32'hDEAD_BEEF);

        run_fill(15'h0050, 1'b0, 0, 15'd0, 32'd0, -1);
        check("beat5_data", got[5], 128'h00000014_00000015_00000016_00000017);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
